data_tcm_arbiter: RTL
=====================

Name: data_tcm_arbiter

Overview:
- Shares the single-ported data TCM between two requesters: port 0 (core load/store unit) and port 1 (debug/DMA master).
- Arbitrates requests and converts byte-address + access size into word-aligned TCM accesses with byte enables.
- Tracks in-flight reads through the TCM's fixed read latency and returns aligned, sign/zero-extended load data and write acks to the owning port.
- Sits between the requesters and data_tcm; the only master of data_tcm.

Parameters:
- DATA_WIDTH, 32, data bus width; fixed at 32.
- ADDR_WIDTH, 32, byte address width.
- TCM_BYTES, 1024, TCM size in bytes; a higher address is an error.
- READ_LATENCY, 1, cycles from TCM access to valid tcm_data_i; legal range 1..3.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- pN_req_i  in  1  port N request (N = 0, 1, same set per port)
- pN_gnt_o  out  1  port N request accepted this cycle
- pN_addr_i  in  ADDR_WIDTH  byte address
- pN_we_i  in  1  1 = store, 0 = load
- pN_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
- pN_unsigned_i  in  1  1 = zero-extend load, 0 = sign-extend load
- pN_wdata_i  in  32  store data, right-aligned
- pN_rvalid_o  out  1  response pulse for an earlier grant
- pN_rdata_o  out  32  load result; 0 unless rvalid on a load
- pN_err_o  out  1  qualifies rvalid; access was faulted
- tcm_addr_o  out  ADDR_WIDTH  word-aligned byte address ([1:0] = 0)
- tcm_data_o  out  32  lane-shifted store data
- tcm_we_o  out  1  TCM write enable
- tcm_be_o  out  4  TCM byte enables
- tcm_data_i  in  32  TCM read data, READ_LATENCY cycles after access

Behaviour:
- Reset:
  - All outputs go to 0 and the response pipeline is cleared.
  - Round-robin pointer is set to port 0.
  - Responses for accesses in flight at reset are dropped and never emitted.
- Grant:
  - Combinational, same cycle as req; at most one gnt per cycle.
  - A request holds addr/we/size/wdata stable until granted.
  - Arbitration policy is set by the optional feature.
- Access drive (granted cycle only):
  - tcm_addr_o = {addr[ADDR_WIDTH-1:2], 2'b00}.
  - Byte: be = 0001 << addr[1:0].
  - Half: be = 0011 << addr[1:0].
  - Word: be = 1111.
  - Store: tcm_data_o = wdata replicated into lanes, tcm_we_o = 1.
  - Load: tcm_we_o = 0, be still driven.
- Idle cycle: tcm_we_o = 0, tcm_be_o = 0, tcm_addr_o/tcm_data_o = 0.
- Faults: misaligned (half with addr[0] = 1, word with addr[1:0] != 0), size 11, or addr + access bytes > TCM_BYTES.
  - A faulting access is still granted.
  - TCM is not driven: we = 0, be = 0.
  - Response carries err = 1 and rdata = 0.
- Response pipeline:
  - READ_LATENCY-deep shift register of {valid, port, we, offset[1:0], size, unsigned, err}.
  - Each granted access, load or store, produces exactly one pN_rvalid_o pulse exactly READ_LATENCY cycles after gnt.
  - Loads: rdata = tcm_data_i >> (8 * offset), masked to size, then sign- or zero-extended.
  - Stores: rdata = 0.
- Back-to-back grants every cycle are legal, including alternating ports and store-after-load to the same word.
  - A load observes a store granted in an earlier cycle.
- Simultaneous req from both ports: one granted, the loser's gnt = 0; the loser keeps req high.

Optional Feature:
- Macro: TCM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - On a contested cycle, the port not granted last contested cycle wins.
  - The pointer updates only on contested grants.
- Undefined: fixed priority; port 0 always wins and port 1 may starve.

Test Plan:
- Port 0 word store addr 0x10 data 0xDEADBEEF, then load addr 0x10 -> store gnt with tcm_be_o = 1111; load rvalid READ_LATENCY cycles after gnt with rdata 0xDEADBEEF, err 0.
- Load byte addr 0x13, signed, then unsigned, after the store above -> rdata 0xFFFFFFDE, then 0x000000DE.
- Store half 0xA5A5 at 0x22 -> tcm_be_o = 1100, tcm_addr_o = 0x20; load word 0x20 returns 0xA5A5xxxx with the lower half unchanged.
- Fault cases:
  - Word load at 0x11 -> err = 1, rdata 0, no TCM write.
  - Word store at 0x400 (TCM_BYTES = 1024) -> err = 1, tcm_we_o stays 0.
- Both ports req continuously for 6 cycles:
  - RR_EN defined -> gnt alternates p0, p1, ...
  - RR_EN undefined -> p0 granted all 6 cycles.
  - In both cases responses land on the correct port in order.
- Assert rst while a load is in flight (READ_LATENCY = 2) -> no rvalid on either port afterwards; all outputs 0 during reset.

Source files
------------

// File: rtl/data_tcm_arbiter.sv
// -----------------------------------------------------------------------------
// data_tcm_arbiter
//
// The only master of the single-ported data TCM. Two requesters share it:
//   port 0 : core load/store unit
//   port 1 : debug / DMA master
//
// Each cycle at most one request is granted, combinationally in the same
// cycle. The granted byte-address/size is turned into a word-aligned TCM
// access with byte enables. Every grant, load or store, returns exactly one
// response pulse on the owning port READ_LATENCY cycles later. Load data is
// lane-aligned and sign- or zero-extended. Faulting accesses (misaligned,
// illegal size, or beyond TCM_BYTES) are still granted, but they never touch
// the TCM and they answer with err = 1 and rdata = 0.
//
// Handshake: a requester raises pN_req_i and holds addr/we/size/wdata stable
// until it sees pN_gnt_o high in the same cycle. The request is accepted in
// that cycle. pN_rvalid_o is a one-cycle pulse with no back-pressure, and
// pN_err_o and pN_rdata_o are meaningful only while it is high.
//
// Optional build macro:
//   TCM_ARB_RR_EN  defined   : round-robin on contested cycles
//                  undefined : fixed priority, port 0 always wins
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   pN_req_i / pN_gnt_o        request / same-cycle grant (N = 0, 1)
//   pN_addr_i, pN_we_i         byte address, 1 = store
//   pN_size_i, pN_unsigned_i   00 byte, 01 half, 10 word; zero-extend loads
//   pN_wdata_i                 right-aligned store data
//   pN_rvalid_o, pN_rdata_o,
//   pN_err_o                   response pulse, load data, fault flag
//   tcm_addr_o, tcm_data_o,
//   tcm_we_o, tcm_be_o         TCM access (all zero on idle cycles)
//   tcm_data_i                 TCM read data, READ_LATENCY cycles after access
// -----------------------------------------------------------------------------
module data_tcm_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int TCM_BYTES    = 1024,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p0_req_i,
    output logic                  p0_gnt_o,
    input  logic [ADDR_WIDTH-1:0] p0_addr_i,
    input  logic                  p0_we_i,
    input  logic [1:0]            p0_size_i,
    input  logic                  p0_unsigned_i,
    input  logic [DATA_WIDTH-1:0] p0_wdata_i,
    output logic                  p0_rvalid_o,
    output logic [DATA_WIDTH-1:0] p0_rdata_o,
    output logic                  p0_err_o,
    input  logic                  p1_req_i,
    output logic                  p1_gnt_o,
    input  logic [ADDR_WIDTH-1:0] p1_addr_i,
    input  logic                  p1_we_i,
    input  logic [1:0]            p1_size_i,
    input  logic                  p1_unsigned_i,
    input  logic [DATA_WIDTH-1:0] p1_wdata_i,
    output logic                  p1_rvalid_o,
    output logic [DATA_WIDTH-1:0] p1_rdata_o,
    output logic                  p1_err_o,
    output logic [ADDR_WIDTH-1:0] tcm_addr_o,
    output logic [DATA_WIDTH-1:0] tcm_data_o,
    output logic                  tcm_we_o,
    output logic [3:0]            tcm_be_o,
    input  logic [DATA_WIDTH-1:0] tcm_data_i
);

    // One entry of the response pipeline.
    typedef struct packed {
        logic       valid;
        logic       port;
        logic       we;
        logic [1:0] offset;
        logic [1:0] size;
        logic       uns;
        logic       err;
    } rsp_t;

    // ---------------------------------------------------------------- arbiter
    logic any_req;
    logic sel;          // port that owns this cycle's grant

    // Grants are forced low while reset is held so every output reads 0.
    assign any_req = (p0_req_i | p1_req_i) & ~rst;

`ifdef TCM_ARB_RR_EN
    logic contested;
    logic rr_ptr;       // port that wins the next contested cycle

    assign contested = p0_req_i & p1_req_i;
    assign sel       = contested ? rr_ptr : p1_req_i;

    // The pointer moves only when both ports competed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else if (contested) begin
            rr_ptr <= ~rr_ptr;
        end
    end
`else
    assign sel = ~p0_req_i;
`endif

    assign p0_gnt_o = any_req & ~sel;
    assign p1_gnt_o = any_req &  sel;

    // --------------------------------------------------------- selected access
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic [1:0]            size;
    logic                  uns;
    logic [DATA_WIDTH-1:0] wdata;

    assign addr  = sel ? p1_addr_i     : p0_addr_i;
    assign we    = sel ? p1_we_i       : p0_we_i;
    assign size  = sel ? p1_size_i     : p0_size_i;
    assign uns   = sel ? p1_unsigned_i : p0_unsigned_i;
    assign wdata = sel ? p1_wdata_i    : p0_wdata_i;

    logic [2:0]            nbytes;
    logic [3:0]            be;
    logic [DATA_WIDTH-1:0] lanes;
    logic [ADDR_WIDTH:0]   end_addr;   // one extra bit so the sum cannot wrap
    logic                  fault;

    always_comb begin
        nbytes = 3'd4;
        be     = 4'b1111;
        lanes  = wdata;
        case (size)
            2'b00: begin
                nbytes = 3'd1;
                be     = 4'b0001 << addr[1:0];
                lanes  = {4{wdata[7:0]}};
            end
            2'b01: begin
                nbytes = 3'd2;
                be     = 4'b0011 << addr[1:0];
                lanes  = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign end_addr = {1'b0, addr} + (ADDR_WIDTH+1)'(nbytes);
    assign fault    = (size == 2'b11)
                    | ((size == 2'b01) & addr[0])
                    | ((size == 2'b10) & (addr[1:0] != 2'b00))
                    | (end_addr > (ADDR_WIDTH+1)'(TCM_BYTES));

    // TCM is driven only for a granted, non-faulting access.
    always_comb begin
        tcm_addr_o = '0;
        tcm_data_o = '0;
        tcm_we_o   = 1'b0;
        tcm_be_o   = 4'b0000;
        if (any_req && !fault) begin
            tcm_addr_o = {addr[ADDR_WIDTH-1:2], 2'b00};
            tcm_be_o   = be;
            if (we) begin
                tcm_we_o   = 1'b1;
                tcm_data_o = lanes;
            end
        end
    end

    // ------------------------------------------------------- response pipeline
    rsp_t                        rsp_in;
    rsp_t [READ_LATENCY-1:0]     pipe;

    always_comb begin
        rsp_in        = '0;
        rsp_in.valid  = any_req;
        rsp_in.port   = sel;
        rsp_in.we     = we;
        rsp_in.offset = addr[1:0];
        rsp_in.size   = size;
        rsp_in.uns    = uns;
        rsp_in.err    = fault;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe <= '0;
        end else begin
            pipe[0] <= rsp_in;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    rsp_t                  head;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] ext;
    logic                  load_ok;

    assign head    = pipe[READ_LATENCY-1];
    assign shifted = tcm_data_i >> {head.offset, 3'b000};
    assign load_ok = head.valid & ~head.we & ~head.err;

    always_comb begin
        ext = shifted;
        case (head.size)
            2'b00:   ext = {{24{~head.uns & shifted[7]}},  shifted[7:0]};
            2'b01:   ext = {{16{~head.uns & shifted[15]}}, shifted[15:0]};
            default: ;
        endcase
    end

    assign p0_rvalid_o = head.valid & ~head.port;
    assign p1_rvalid_o = head.valid &  head.port;
    assign p0_err_o    = p0_rvalid_o & head.err;
    assign p1_err_o    = p1_rvalid_o & head.err;
    assign p0_rdata_o  = (load_ok & ~head.port) ? ext : '0;
    assign p1_rdata_o  = (load_ok &  head.port) ? ext : '0;

endmodule
